if_branch_fetch: RTL
====================

# if_branch_fetch

Instruction-fetch front end of the 5-stage RISC-V pipeline. It owns the program counter and drives the IF/ID pipeline register: PC, raw instruction word, and the flush strobe. A direct-mapped branch history table (2-bit saturating counters) and a branch target buffer predict the next PC. EX-stage branch resolution trains the predictor and redirects the PC on a mispredict.

## Interface
Parameters:
- `BHT_ENTRIES`, 16: number of BHT/BTB entries; power of two, at least 2. `IDX = log2(BHT_ENTRIES)`.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `pc_write`  in  1  from the hazard unit; 0 holds the PC (load-use stall).
- `imem_addr`  out  32  instruction-memory address; always equals `pc`.
- `imem_rdata`  in  32  combinational instruction-memory read data.
- `if_pc`  out  32  current PC, to the IF/ID register.
- `if_Instruction_Code`  out  32  equals `imem_rdata`, to the IF/ID register.
- `if_pred_taken`  out  1  prediction made for the current PC; piped down to EX.
- `if_pred_target`  out  32  predicted next PC; piped down to EX.
- `ex_branch_valid`  in  1  a resolved branch or jump is in EX this cycle.
- `ex_branch_pc`  in  32  PC of the resolved instruction.
- `ex_branch_taken`  in  1  actual direction.
- `ex_branch_target`  in  32  actual taken target.
- `ex_pred_taken`  in  1  `if_pred_taken` carried with this instruction.
- `ex_pred_target`  in  32  `if_pred_target` carried with this instruction.
- `IF_Flush`  out  1  squashes IF/ID (and ID/EX) at the next edge.
- `branch_count`  out  16  resolved branches, wraps at 16'hFFFF.
- `mispredict_count`  out  16  mispredicts, wraps at 16'hFFFF.

## Operation
- Index is `pc[IDX+1:2]`. Tag is `pc[31:IDX+2]`. Each entry holds `valid`, `tag`, `target[31:0]`, and `ctr[1:0]`.
- Lookup is combinational on `pc`.
  - `hit = valid & (tag match)`.
  - `if_pred_taken = hit & ctr[1]`.
  - `if_pred_target = if_pred_taken ? target : pc+4`.
- Mispredict, combinational: `mis = ex_branch_valid & ((ex_branch_taken != ex_pred_taken) | (ex_branch_taken & ex_pred_taken & ex_branch_target != ex_pred_target))`.
- `IF_Flush = mis`. It is never asserted during reset.
- Next-PC priority:
  1. `reset` selects `RESET_PC`.
  2. `mis` selects `ex_branch_taken ? ex_branch_target : ex_branch_pc+4`.
  3. `pc_write==0` holds `pc`.
  4. Otherwise `if_pred_target`.
- A mispredict overrides a stall.
- Training happens at the clock edge when `ex_branch_valid`, at index and tag taken from `ex_branch_pc`:
  - Tag hit: `ctr` saturating ±1 (00 to 11), taken increments. If taken, `target <= ex_branch_target`.
  - Tag miss, taken: allocate the entry with `valid=1`, new tag, `target=ex_branch_target`, `ctr=2'b10`.
  - Tag miss, not taken: no change.
- Counters update at the clock edge:
  - `branch_count` increments on `ex_branch_valid`.
  - `mispredict_count` increments on `mis`.
- Arithmetic: PC adds are 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0. PC bits [1:0] are carried unchanged; no alignment check is done.
- Reset clears:
  - `pc = RESET_PC`
  - all `valid = 0`
  - all `ctr = 2'b01`
  - both counters to 0
  
  Targets and tags need no reset.

## Timing
- Reset values, one cycle after `reset` is sampled high:
  - `if_pc = imem_addr = RESET_PC`
  - `if_pred_taken = 0`
  - `if_pred_target = RESET_PC+4`
  - `IF_Flush = 0`
  - counters = 0
- Reset mid-operation: `reset` takes priority over `mis`, stall, and training. No BHT write occurs in the reset cycle.
- Fetch has zero internal latency. `if_*` outputs are valid in the same cycle the PC register updates. The PC advances once per edge.
- `IF_Flush` is asserted in the same cycle `mis` is detected. The wrong-path instruction is squashed at that edge, and the correct PC appears in the following cycle.
- A lookup and a training write to the same index in the same cycle: the lookup sees the pre-edge contents. The write is visible from the next cycle.
- `pc_write==0` with no `mis`: `pc` and all `if_*` outputs stay stable. Training still occurs.
- Back-to-back mispredicts on consecutive cycles are each honoured. The later one wins the PC.

## Test plan
- **Reset:** hold `reset` 2 cycles, with `RESET_PC`=32'h100.
  - Required: `if_pc`=32'h100, `if_pred_taken`=0, `IF_Flush`=0, counters=0.
- **Sequential fetch:** run 4 cycles with no branches and `pc_write`=1.
  - Required: `if_pc` = 100, 104, 108, 10C.
- **Stall:** drive `pc_write`=0 for 3 cycles at PC 108.
  - Required: `if_pc` stays 108. On release it goes to 10C.
- **Cold mispredict:** branch at 104, taken, target 200, `ex_pred_taken`=0.
  - Required: `IF_Flush`=1 for one cycle, next `if_pc`=200, `mispredict_count`=1, entry allocated with `ctr`=10.
  - Later fetch of 104: `if_pred_taken`=1, `if_pred_target`=200.
- **Counter saturation:** resolve the branch at 104 not-taken twice.
  - Required: `ctr` goes 10→01→00 and prediction becomes not-taken.
  - Two further taken resolutions: `ctr` goes 01→10 and prediction is taken again.
- **Mispredict during stall:** `pc_write`=0 and `mis` with a not-taken branch at 300.
  - Required: `IF_Flush`=1, next `if_pc`=304.
  - Simultaneous `reset`: `if_pc`=`RESET_PC` and no counter increment.

Source files
------------

// File: rtl/if_branch_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_branch_fetch
// Brief    : Instruction-fetch front end. Owns the PC, predicts the next PC
//            with a direct-mapped BHT (2-bit counters) plus BTB, and redirects
//            the PC when EX resolves a mispredicted branch.
// Revision : 1.0 - initial release
// ============================================================================
module if_branch_fetch #(
  parameter int          BHT_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_Instruction_Code,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        ex_branch_valid,
  input  logic [31:0] ex_branch_pc,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        IF_Flush,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int c_IDX  = $clog2(BHT_ENTRIES);
  localparam int c_TAGW = 32 - c_IDX - 2;

  // Predictor storage: valid/ctr are reset, tag/target are qualified by valid
  logic                r_valid  [BHT_ENTRIES];
  logic [1:0]          r_ctr    [BHT_ENTRIES];
  logic [c_TAGW-1:0]   r_tag    [BHT_ENTRIES];
  logic [31:0]         r_target [BHT_ENTRIES];

  logic [31:0]         r_pc;
  logic [15:0]         r_branch_count;
  logic [15:0]         r_mispredict_count;

  logic [c_IDX-1:0]    w_rd_idx;
  logic [c_TAGW-1:0]   w_rd_tag;
  logic                w_rd_hit;
  logic [c_IDX-1:0]    w_wr_idx;
  logic [c_TAGW-1:0]   w_wr_tag;
  logic                w_wr_hit;
  logic [1:0]          w_ctr_next;
  logic                w_mis;
  logic [31:0]         w_pc_plus4;
  logic [31:0]         w_ex_plus4;
  logic [31:0]         w_pred_target;
  logic                w_pred_taken;
  logic [31:0]         w_pc_next;

  assign w_rd_idx   = r_pc[c_IDX+1:2];
  assign w_rd_tag   = r_pc[31:c_IDX+2];
  assign w_wr_idx   = ex_branch_pc[c_IDX+1:2];
  assign w_wr_tag   = ex_branch_pc[31:c_IDX+2];
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_ex_plus4 = ex_branch_pc + 32'd4;

  // Combinational lookup on the current PC; sees pre-edge table contents
  always_comb begin
    w_rd_hit      = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    w_pred_taken  = w_rd_hit && r_ctr[w_rd_idx][1];
    w_pred_target = w_pred_taken ? r_target[w_rd_idx] : w_pc_plus4;
  end

  // Mispredict detection: wrong direction, or taken with a wrong target
  always_comb begin
    w_mis = ex_branch_valid &&
            ((ex_branch_taken != ex_pred_taken) ||
             (ex_branch_taken && ex_pred_taken && (ex_branch_target != ex_pred_target)));
  end

  // Training-side hit and saturating counter update
  always_comb begin
    w_wr_hit   = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
    w_ctr_next = r_ctr[w_wr_idx];
    if (ex_branch_taken) begin
      if (r_ctr[w_wr_idx] != 2'b11) w_ctr_next = r_ctr[w_wr_idx] + 2'd1;
    end else begin
      if (r_ctr[w_wr_idx] != 2'b00) w_ctr_next = r_ctr[w_wr_idx] - 2'd1;
    end
  end

  // Next-PC select: reset, then redirect (overrides stall), then hold, then predict
  always_comb begin
    w_pc_next = w_pred_target;
    if (reset)
      w_pc_next = RESET_PC;
    else if (w_mis)
      w_pc_next = ex_branch_taken ? ex_branch_target : w_ex_plus4;
    else if (!pc_write)
      w_pc_next = r_pc;
  end

  // PC register and event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc               <= RESET_PC;
      r_branch_count     <= 16'd0;
      r_mispredict_count <= 16'd0;
    end else begin
      r_pc <= w_pc_next;
      if (ex_branch_valid) r_branch_count     <= r_branch_count + 16'd1;
      if (w_mis)           r_mispredict_count <= r_mispredict_count + 16'd1;
    end
  end

  // Valid bits and direction counters; a tag miss only allocates when taken
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (ex_branch_valid) begin
      if (w_wr_hit) begin
        r_ctr[w_wr_idx] <= w_ctr_next;
      end else if (ex_branch_taken) begin
        r_valid[w_wr_idx] <= 1'b1;
        r_ctr[w_wr_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target capture on every taken resolution (tag unchanged on a hit)
  always_ff @(posedge clk) begin
    if (!reset && ex_branch_valid && ex_branch_taken) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= ex_branch_target;
    end
  end

  assign imem_addr           = r_pc;
  assign if_pc               = r_pc;
  assign if_Instruction_Code = imem_rdata;
  assign if_pred_taken       = w_pred_taken;
  assign if_pred_target      = w_pred_target;
  assign IF_Flush            = w_mis && !reset;
  assign branch_count        = r_branch_count;
  assign mispredict_count    = r_mispredict_count;

endmodule
`default_nettype wire
